// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared FSM encodings, stall-source priority and defaults for pipe_stall_ctrl
package pipe_ctrl_pkg;

  localparam int MD_TIMEOUT_DEF = 64;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MD_BUSY = 2'd1;
  localparam logic [1:0] ST_MD_DONE = 2'd2;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LW   = 2'd1,
    SRC_MD   = 2'd2,
    SRC_MEM  = 2'd3
  } stall_src_e;

  // Highest-priority stall source wins: dmem wait, then mul/div, then load-use.
  function automatic stall_src_e stall_src(input logic mem_wait, input logic md_wait,
                                           input logic lw_wait);
    if (mem_wait) return SRC_MEM;
    if (md_wait) return SRC_MD;
    if (lw_wait) return SRC_LW;
    return SRC_NONE;
  endfunction

endpackage

// File: rtl/md_timeout_ctr.sv
// rtl/md_timeout_ctr.sv - mul/div timeout counter with clear, enable and terminal-count flag
module md_timeout_ctr
  import pipe_ctrl_pkg::*;
#(
  parameter int TC = MD_TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = $clog2(TC + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  assign tc_o = en_i && (cnt_q == W'(TC - 1));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush sequencer with mul/div handshake
// Optional perf counters enabled by defining PIPE_STALL_PERF_EN.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF
`ifdef PIPE_STALL_PERF_EN
  , parameter int PERF_W = 32
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic lw_stall,
  input  logic pc_src_e,
  input  logic md_op_e,
  input  logic md_done,
  input  logic dmem_ready,
  output logic stall_f,
  output logic stall_d,
  output logic stall_e,
  output logic stall_m,
  output logic flush_d,
  output logic flush_e,
  output logic flush_m,
  output logic flush_w,
  output logic md_start,
  output logic md_err,
  output logic busy
`ifdef PIPE_STALL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_md_cyc,
  output logic [PERF_W-1:0] perf_mem_cyc,
  output logic [PERF_W-1:0] perf_lw_cyc
`endif
);

  logic [1:0] state_q, state_d;
  logic       md_tc, md_cnt_en, md_cnt_clr;
  logic       start_c, err_c, md_wait, redirect;
  stall_src_e src;

  assign md_cnt_en  = (state_q == ST_MD_BUSY);
  assign md_cnt_clr = !md_cnt_en || md_done || md_tc;

  md_timeout_ctr #(.TC(MD_TIMEOUT)) u_md_ctr (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (md_cnt_clr),
    .en_i    (md_cnt_en),
    .tc_o    (md_tc)
  );

  // A memory wait freezes RUN and MD_DONE; MD_BUSY keeps listening for done/timeout.
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    err_c   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (md_op_e && dmem_ready) begin
          start_c = 1'b1;
          state_d = ST_MD_BUSY;
        end
      end
      ST_MD_BUSY: begin
        if (md_done) begin
          state_d = ST_MD_DONE;
        end else if (md_tc) begin
          err_c   = 1'b1;
          state_d = ST_MD_DONE;
        end
      end
      ST_MD_DONE: begin
        if (dmem_ready) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else state_q <= state_d;
  end

  assign md_wait  = (state_q == ST_MD_BUSY) || ((state_q == ST_RUN) && md_op_e);
  assign src      = stall_src(!dmem_ready, md_wait, lw_stall && !pc_src_e);
  // Redirect only when E is free to move; otherwise the branch re-presents later.
  assign redirect = dmem_ready && !md_wait && pc_src_e;

  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    flush_w  = 1'b0;
    md_start = 1'b0;
    md_err   = 1'b0;
    if (!reset) begin
      md_start = start_c;
      md_err   = err_c;
      case (src)
        SRC_MEM: begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = 1'b1;
          flush_w = 1'b1;
        end
        SRC_MD: begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
        end
        SRC_LW: begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
        default: ;
      endcase
      if (redirect) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  assign busy = (state_q != ST_RUN);

`ifdef PIPE_STALL_PERF_EN
  logic [PERF_W-1:0] perf_md_q, perf_mem_q, perf_lw_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_md_q  <= '0;
      perf_mem_q <= '0;
      perf_lw_q  <= '0;
    end else begin
      if (src == SRC_MD && perf_md_q != '1) perf_md_q <= perf_md_q + PERF_W'(1);
      if (src == SRC_MEM && perf_mem_q != '1) perf_mem_q <= perf_mem_q + PERF_W'(1);
      if (src == SRC_LW && perf_lw_q != '1) perf_lw_q <= perf_lw_q + PERF_W'(1);
    end
  end

  assign perf_md_cyc  = perf_md_q;
  assign perf_mem_cyc = perf_mem_q;
  assign perf_lw_cyc  = perf_lw_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - table-driven and sequence checks for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  logic reset, lw_stall, pc_src_e, md_op_e, md_done, dmem_ready;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_m, flush_w;
  logic md_start, md_err, busy;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MD_TIMEOUT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .lw_stall   (lw_stall),
    .pc_src_e   (pc_src_e),
    .md_op_e    (md_op_e),
    .md_done    (md_done),
    .dmem_ready (dmem_ready),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .stall_e    (stall_e),
    .stall_m    (stall_m),
    .flush_d    (flush_d),
    .flush_e    (flush_e),
    .flush_m    (flush_m),
    .flush_w    (flush_w),
    .md_start   (md_start),
    .md_err     (md_err),
    .busy       (busy)
  );

  // Output vector order: stall_f,d,e,m | flush_d,e,m,w | md_start, md_err, busy
  localparam logic [10:0] O_IDLE   = 11'b0000_0000_000;
  localparam logic [10:0] O_MEM    = 11'b1111_0001_000;
  localparam logic [10:0] O_LW     = 11'b1100_0100_000;
  localparam logic [10:0] O_REDIR  = 11'b0000_1100_000;
  localparam logic [10:0] O_START  = 11'b1110_0010_100;
  localparam logic [10:0] O_MDBUSY = 11'b1110_0010_001;
  localparam logic [10:0] O_MDERR  = 11'b1110_0010_011;
  localparam logic [10:0] O_MEMBSY = 11'b1111_0001_001;
  localparam logic [10:0] O_MDDONE = 11'b0000_0000_001;

  typedef struct {
    string       name;
    logic        lw, pc, op, done, rdy;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[9];
  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [10:0] outs();
    return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
            md_start, md_err, busy};
  endfunction

  task automatic drive(input logic lw, input logic pc, input logic op, input logic done,
                       input logic rdy);
    lw_stall   = lw;
    pc_src_e   = pc;
    md_op_e    = op;
    md_done    = done;
    dmem_ready = rdy;
  endtask

  // Inputs settle 1ns after posedge; outputs sampled mid-cycle, then advance one clock.
  task automatic cyc(input string name, input logic [10:0] exp);
    logic [10:0] act;
    #4;
    act = outs();
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{"idle",          0, 0, 0, 0, 1, O_IDLE};
    tbl[1] = '{"lw_only",       1, 0, 0, 0, 1, O_LW};
    tbl[2] = '{"pc_only",       0, 1, 0, 0, 1, O_REDIR};
    tbl[3] = '{"lw_and_pc",     1, 1, 0, 0, 1, O_REDIR};
    tbl[4] = '{"mem_wait",      0, 0, 0, 0, 0, O_MEM};
    tbl[5] = '{"mem_over_pc",   0, 1, 0, 0, 0, O_MEM};
    tbl[6] = '{"mem_over_lw",   1, 0, 0, 0, 0, O_MEM};
    tbl[7] = '{"mem_over_md",   0, 0, 1, 0, 0, O_MEM};
    tbl[8] = '{"done_in_run",   0, 0, 0, 1, 1, O_IDLE};

    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    cyc("reset_gated", O_IDLE);
    reset = 1'b0;
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc("quiet_after_reset", O_IDLE);

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].lw, tbl[i].pc, tbl[i].op, tbl[i].done, tbl[i].rdy);
      cyc(tbl[i].name, tbl[i].exp);
    end
    drive(0, 0, 0, 0, 1);
    cyc("table_exit_idle", O_IDLE);

    // mul/div with done on the 4th busy cycle
    md_op_e = 1'b1;
    cyc("md_start", O_START);
    for (int i = 0; i < 3; i++) cyc("md_busy", O_MDBUSY);
    md_done = 1'b1;
    cyc("md_done_cycle", O_MDBUSY);
    md_done = 1'b0;
    cyc("md_done_state", O_MDDONE);
    md_op_e = 1'b0;
    cyc("md_back_to_run", O_IDLE);

    // timeout: 8 busy cycles, error on the 8th
    md_op_e = 1'b1;
    cyc("to_start", O_START);
    for (int k = 1; k <= 8; k++) cyc((k == 8) ? "to_err" : "to_busy", (k == 8) ? O_MDERR : O_MDBUSY);
    cyc("to_done_state", O_MDDONE);
    md_op_e = 1'b0;
    cyc("to_back_to_run", O_IDLE);

    // deferred redirect under memory wait
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("mem_defers_pc", O_MEM);
    dmem_ready = 1'b1;
    cyc("pc_after_mem", O_REDIR);
    pc_src_e = 1'b0;

    // md_done accepted while memory waits in MD_BUSY
    md_op_e = 1'b1;
    cyc("mb_start", O_START);
    cyc("mb_busy", O_MDBUSY);
    dmem_ready = 1'b0;
    md_done = 1'b1;
    cyc("mb_mem_in_busy", O_MEMBSY);
    dmem_ready = 1'b1;
    md_done = 1'b0;
    cyc("mb_done_state", O_MDDONE);
    md_op_e = 1'b0;
    cyc("mb_back_to_run", O_IDLE);

    // reset on the 3rd MD_BUSY cycle
    md_op_e = 1'b1;
    cyc("rb_start", O_START);
    cyc("rb_busy1", O_MDBUSY);
    cyc("rb_busy2", O_MDBUSY);
    reset = 1'b1;
    cyc("rb_reset_in_busy", O_MDDONE);
    reset = 1'b0;
    md_op_e = 1'b0;
    cyc("rb_after_reset", O_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
